// File: rtl/apb_rr_scheduler.sv
// Round-robin sequencer that shares one APB master port among NUM_REQ requesters.
// Optional APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES cycles without pready_i.
module apb_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               psel_d, penable_d, pwrite_d, err_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [DATA_W-1:0]  pwdata_d, rdata_d;
  logic [NUM_REQ-1:0] done_d;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
  end

  // A requester being completed this cycle must not win the next grant.
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    eligible    = req_valid_i & ~req_done_o;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    tmo_cnt_d = tmo_cnt_q;
    psel_d    = psel_o;
    penable_d = penable_o;
    pwrite_d  = pwrite_o;
    paddr_d   = paddr_o;
    pwdata_d  = pwdata_o;
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d   = SETUP;
          ptr_d     = grant_idx;
          idx_d     = grant_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write_i[grant_idx];
          paddr_d   = addr_arr[grant_idx];
          pwdata_d  = wdata_arr[grant_idx];
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        tmo_cnt_d = '0;
      end

      ACCESS: begin
        if (pready_i || (TMO_EN && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
          state_d         = IDLE;
          done_d[idx_q]   = 1'b1;
          err_d           = !pready_i;
          rdata_d         = (pready_i && !pwrite_o) ? prdata_i : '0;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          pwrite_d        = 1'b0;
          paddr_d         = '0;
          pwdata_d        = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset also discards an in-flight command and re-arms the pointer so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
      tmo_cnt_q   <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      req_done_o  <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      psel_o      <= psel_d;
      penable_o   <= penable_d;
      pwrite_o    <= pwrite_d;
      paddr_o     <= paddr_d;
      pwdata_o    <= pwdata_d;
      req_done_o  <= done_d;
      rsp_rdata_o <= rdata_d;
      rsp_err_o   <= err_d;
    end
  end

endmodule
